net_perf_monitor: RTL and testbench
===================================

# net_perf_monitor

Parametrised, runtime-configurable performance monitor for the network stack's AXI-Stream/metadata handshakes. Counts qualified handshakes and accumulated byte lengths on NUM_CH channels over a programmable cycle window started by a trigger handshake. At window end it publishes a registered snapshot, in one-shot or continuous mode. It sits beside network_stack on the aclk domain and is passively tapped onto valid/ready pairs; its outputs feed an ILA or control registers.

## Interface
- NUM_CH, 4: number of monitored channels (1..16).
- LEN_W, 16: width of each per-event byte-length field.
- EVT_W, 32: width of the event counters.
- BYTE_W, 64: width of the byte counters.
- CYC_W, 32: width of the window length and cycle counter.
- aclk  in  1  clock; all logic is rising-edge.
- areset  in  1  reset, asynchronous and active-high.
- arm  in  1  level enable; deassertion aborts the current window.
- mode  in  1  0 = one-shot, 1 = continuous.
- window_cycles  in  CYC_W  window length in cycles; 0 is treated as 1.
- trig_sel  in  $clog2(NUM_CH) (min 1)  channel whose first handshake starts the window.
- ev_valid  in  NUM_CH  tapped valid per channel.
- ev_ready  in  NUM_CH  tapped ready per channel.
- ev_ok  in  NUM_CH  qualifier per channel (e.g. status error field == 0); the handshake counts only when high.
- ev_len  in  NUM_CH*LEN_W  byte length per channel, packed with channel 0 at the LSBs.
- running  out  1  high in RUN.
- snap_valid  out  1  one-cycle pulse when a new snapshot is available.
- snap_seq  out  16  completed-window count, wraps modulo 2^16.
- snap_events  out  NUM_CH*EVT_W  per-channel event count for the last window.
- snap_bytes  out  NUM_CH*BYTE_W  per-channel byte count for the last window.
- snap_sat  out  NUM_CH  per-channel flag: a counter saturated during the last window.

## Operation
- A fire on channel i is ev_valid[i] & ev_ready[i]. A counted fire is a fire with ev_ok[i] high.
- The FSM has three states: IDLE, ARMED, RUN.
- IDLE: live counters are held at 0. If arm = 1, the next state is ARMED.
- ARMED: wait for a fire on trig_sel; ev_ok is not required for the trigger.
  - On the trigger, latch window_cycles (0 becomes 1), set cyc to 0, and go to RUN.
  - Counted fires in the trigger cycle are included in the window.
- RUN: each cycle, counted fires add 1 to the event counter and ev_len to the byte counter; cyc increments.
  - The final cycle is the one where cyc == latched_len - 1.
- End of window: final values include the final cycle's contributions.
  - The snapshot registers load the final values and snap_seq increments.
  - Live counters and saturation flags clear.
  - mode = 1: stay in RUN and start the next window on the next cycle with cyc = 0. There is no retrigger, and window_cycles is re-latched.
  - mode = 0: go to IDLE.
- arm = 0 in ARMED or RUN: go to IDLE and clear live counters. No snapshot is produced and the snap_* outputs keep their old values.
- Saturation: counters clamp at all-ones and never wrap. The channel's live sat flag is set and published in snap_sat.
- The monitor never drives ready; it is purely observational.

## Timing
- Reset values: the FSM is in IDLE; running, snap_valid, snap_seq, snap_events, snap_bytes, snap_sat and all live counters are 0.
- The snapshot is available one cycle after the final window cycle. snap_valid pulses in that cycle, and snap_* is stable from then until the next pulse.
- running is registered:
  - It rises the cycle after the trigger.
  - It falls the cycle after the final cycle (one-shot) or after the abort.
- Continuous mode has no dead cycles: every cycle belongs to exactly one window.
- When arm is deasserted in the same cycle as the final window cycle, the abort wins and no snapshot is produced.
- Asserting areset mid-window clears everything immediately (asynchronously) and drops any partial window.
- Changes to window_cycles, trig_sel or mode take effect only at the next latch point: the trigger, or the window end for mode.

## Configuration
- PERF_BYTE_CNT_EN defined: byte counters are built, and snap_bytes is driven as specified.
- PERF_BYTE_CNT_EN undefined: the byte counters are not built, ev_len is ignored, and snap_bytes is tied to 0. snap_sat then reflects only the event counters.

## Structure
- Package net_perf_pkg holds:
  - the FSM enum perf_state_t (IDLE, ARMED, RUN);
  - the default widths DEF_EVT_W, DEF_BYTE_W and DEF_CYC_W;
  - SNAP_SEQ_W = 16.
- Sub-module perf_sat_acc: a saturating accumulator with parameter W, inputs clr, en, inc[W-1:0], and outputs q and sat. It is instantiated once per channel for events and once per channel for bytes.

## Test plan
- One-shot: NUM_CH=2, window_cycles=10, mode=0, trig_sel=0.
  - Trigger on channel 0 at cycle T; channel 1 fires with ok and len=64 at T..T+9 and at T+10.
  - Required: one snap_valid at T+10; snap_events[ch1]=10, snap_bytes[ch1]=640, snap_events[ch0]=1, snap_seq=1; FSM returns to IDLE, then ARMED.
- Continuous, 3 windows of 5 cycles, channel 0 firing every cycle:
  - Required: snap_valid at trigger+5, +10 and +15; each snapshot has events=5; snap_seq counts 1, 2, 3.
- ev_ok = 0 on alternate fires over a 100-cycle window with continuous firing:
  - Required: events=50 and bytes=50*len.
- Saturation with EVT_W=4, 20 fires in a window:
  - Required: snap_events=15 and snap_sat=1. The next window, with 3 fires, gives 3 and snap_sat=0.
- Abort: arm drops at window cycle 7 of 10.
  - Required: no snap_valid, snap_* unchanged, running low the next cycle.
  - Repeat with arm dropping on the final cycle: no snapshot.
- window_cycles=0:
  - Required: a 1-cycle window with snap_valid the cycle after the trigger.
  - Also: areset asserted mid-window forces all outputs to 0 with no clock edge.

Source files
------------

// File: rtl/net_perf_pkg.sv
// Shared definitions for the network-stack performance monitor.
//   perf_state_t : monitor FSM encoding (IDLE, ARMED, RUN)
//   DEF_*_W      : default counter widths used by net_perf_monitor
//   SNAP_SEQ_W   : width of the completed-window sequence number
package net_perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } perf_state_t;

  localparam int DEF_EVT_W  = 32;
  localparam int DEF_BYTE_W = 64;
  localparam int DEF_CYC_W  = 32;
  localparam int SNAP_SEQ_W = 16;

endpackage

// File: rtl/perf_sat_acc.sv
// Saturating accumulator: q clamps at all-ones instead of wrapping, and sat
// records that a clamp happened since the last clear.
// Ports:
//   aclk, areset     clock, asynchronous active-high reset
//   clr              synchronous clear (wins over en)
//   en, inc          add inc to q this cycle when en is high
//   q, sat           registered accumulator value and saturation flag
//   q_next, sat_next value/flag including this cycle's contribution (before
//                    clr), so a snapshot taken at the same edge is complete
module perf_sat_acc #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] q,
  output logic         sat,
  output logic [W-1:0] q_next,
  output logic         sat_next
);

  // One extra bit catches the carry that marks an overflow.
  logic [W:0] sum;
  assign sum = {1'b0, q} + {1'b0, inc};

  always_comb begin
    q_next   = q;
    sat_next = sat;
    if (en) begin
      if (sum[W]) begin
        q_next   = '1;
        sat_next = 1'b1;
      end else begin
        q_next = sum[W-1:0];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else begin
      q   <= q_next;
      sat <= sat_next;
    end
  end

endmodule

// File: rtl/net_perf_monitor.sv
// Passive performance monitor for valid/ready handshakes on NUM_CH channels.
// A fire on trig_sel (while armed) opens a window of window_cycles cycles
// (0 treated as 1) that includes the trigger cycle. Qualified fires (ev_ok)
// are counted and their ev_len summed; at window end a snapshot is published
// with a one-cycle snap_valid pulse. mode=1 chains windows back to back.
// Build option: define PERF_BYTE_CNT_EN to build the byte counters; without
// it ev_len is ignored and snap_bytes reads 0.
// Ports:
//   aclk, areset                clock, asynchronous active-high reset
//   arm, mode                   level enable (drop aborts), 0 one-shot/1 continuous
//   window_cycles, trig_sel     window length, trigger channel
//   ev_valid/ev_ready/ev_ok     tapped handshake and qualifier per channel
//   ev_len                      per-channel byte length, channel 0 at LSBs
//   running                     registered, high while in RUN
//   snap_valid, snap_seq        new-snapshot pulse, completed-window count
//   snap_events/bytes/sat       per-channel results of the last window
module net_perf_monitor
  import net_perf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16,
  parameter int EVT_W  = DEF_EVT_W,
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int CYC_W  = DEF_CYC_W,
  localparam int TS_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      arm,
  input  logic                      mode,
  input  logic [CYC_W-1:0]          window_cycles,
  input  logic [TS_W-1:0]           trig_sel,
  input  logic [NUM_CH-1:0]         ev_valid,
  input  logic [NUM_CH-1:0]         ev_ready,
  input  logic [NUM_CH-1:0]         ev_ok,
  input  logic [NUM_CH*LEN_W-1:0]   ev_len,
  output logic                      running,
  output logic                      snap_valid,
  output logic [SNAP_SEQ_W-1:0]     snap_seq,
  output logic [NUM_CH*EVT_W-1:0]   snap_events,
  output logic [NUM_CH*BYTE_W-1:0]  snap_bytes,
  output logic [NUM_CH-1:0]         snap_sat
);

  logic [NUM_CH-1:0] fire, cnt, fire_sh;
  logic              trig_hit, trig_now, win_act, last_cyc, win_end, acc_clr;
  logic [CYC_W-1:0]  len_lat, cur_cyc, cur_len;

  perf_state_t       state_reg, state_next;
  logic [CYC_W-1:0]  cyc_reg, len_reg;
  logic              running_reg, snap_valid_reg;
  logic [SNAP_SEQ_W-1:0]    snap_seq_reg;
  logic [NUM_CH*EVT_W-1:0]  snap_ev_reg;
  logic [NUM_CH*BYTE_W-1:0] snap_by_reg;
  logic [NUM_CH-1:0]        snap_sat_reg;

  logic [NUM_CH*EVT_W-1:0]  ev_nx, ev_live;
  logic [NUM_CH*BYTE_W-1:0] by_nx;
  logic [NUM_CH-1:0]        ev_sat_nx, by_sat_nx, ev_live_sat;

  assign fire     = ev_valid & ev_ready;
  assign cnt      = fire & ev_ok;
  // Shift instead of indexing so trig_sel never addresses past NUM_CH.
  assign fire_sh  = fire >> trig_sel;
  assign trig_hit = fire_sh[0];

  assign len_lat  = (window_cycles == '0) ? CYC_W'(1) : window_cycles;
  assign trig_now = (state_reg == ARMED) && trig_hit;
  // The trigger cycle is window cycle 0, so it is evaluated against the
  // freshly latched length rather than the stored one.
  assign win_act  = trig_now || (state_reg == RUN);
  assign cur_cyc  = (state_reg == RUN) ? cyc_reg : '0;
  assign cur_len  = (state_reg == RUN) ? len_reg : len_lat;
  assign last_cyc = win_act && (cur_cyc == cur_len - CYC_W'(1));
  assign win_end  = last_cyc && arm;          // abort beats window end
  assign acc_clr  = (state_reg == IDLE) || !arm || win_end;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arm) state_next = ARMED;
      ARMED: begin
        if (!arm)          state_next = IDLE;
        else if (trig_now) state_next = (last_cyc && !mode) ? IDLE : RUN;
      end
      RUN: begin
        if (!arm)                   state_next = IDLE;
        else if (last_cyc && !mode) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg      <= IDLE;
      cyc_reg        <= '0;
      len_reg        <= '0;
      running_reg    <= 1'b0;
      snap_valid_reg <= 1'b0;
      snap_seq_reg   <= '0;
      snap_ev_reg    <= '0;
      snap_by_reg    <= '0;
      snap_sat_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      running_reg    <= (state_next == RUN);
      snap_valid_reg <= win_end;
      if (!arm || state_reg == IDLE) cyc_reg <= '0;
      else if (win_act)              cyc_reg <= last_cyc ? '0 : cur_cyc + CYC_W'(1);
      // Window length is re-latched at every window start.
      if (trig_now || win_end) len_reg <= len_lat;
      if (win_end) begin
        snap_seq_reg <= snap_seq_reg + SNAP_SEQ_W'(1);
        snap_ev_reg  <= ev_nx;
        snap_by_reg  <= by_nx;
        snap_sat_reg <= ev_sat_nx | by_sat_nx;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    perf_sat_acc #(.W(EVT_W)) u_ev (
      .aclk     (aclk),
      .areset   (areset),
      .clr      (acc_clr),
      .en       (win_act & cnt[gi]),
      .inc      (EVT_W'(1)),
      .q        (ev_live[gi*EVT_W +: EVT_W]),
      .sat      (ev_live_sat[gi]),
      .q_next   (ev_nx[gi*EVT_W +: EVT_W]),
      .sat_next (ev_sat_nx[gi])
    );
`ifdef PERF_BYTE_CNT_EN
    logic [BYTE_W-1:0] by_live;
    logic              by_live_sat;
    logic              unused_by_live;
    assign unused_by_live = ^{by_live, by_live_sat};
    perf_sat_acc #(.W(BYTE_W)) u_by (
      .aclk     (aclk),
      .areset   (areset),
      .clr      (acc_clr),
      .en       (win_act & cnt[gi]),
      .inc      (BYTE_W'(ev_len[gi*LEN_W +: LEN_W])),
      .q        (by_live),
      .sat      (by_live_sat),
      .q_next   (by_nx[gi*BYTE_W +: BYTE_W]),
      .sat_next (by_sat_nx[gi])
    );
`endif
  end

`ifndef PERF_BYTE_CNT_EN
  logic unused_len;
  assign unused_len = ^ev_len;
  assign by_nx      = '0;
  assign by_sat_nx  = '0;
`endif

  // Live counters are only observed through q_next at the window end.
  logic unused_live;
  assign unused_live = ^{ev_live, ev_live_sat};

  assign running     = running_reg;
  assign snap_valid  = snap_valid_reg;
  assign snap_seq    = snap_seq_reg;
  assign snap_events = snap_ev_reg;
  assign snap_bytes  = snap_by_reg;
  assign snap_sat    = snap_sat_reg;

endmodule

// File: tb/tb_net_perf_monitor.sv
module tb_net_perf_monitor;

`ifdef PERF_BYTE_CNT_EN
  localparam int BEN = 1;
`else
  localparam int BEN = 0;
`endif

  logic        aclk = 1'b0;
  logic        areset, arm, arm_s, mode, trig_sel;
  logic [31:0] window_cycles;
  logic [1:0]  ev_valid, ev_ready, ev_ok;
  logic [31:0] ev_len;

  logic         running_m, snap_valid_m, running_s, snap_valid_s;
  logic [15:0]  snap_seq_m, snap_seq_s;
  logic [63:0]  snap_events_m;
  logic [7:0]   snap_events_s;
  logic [127:0] snap_bytes_m, snap_bytes_s;
  logic [1:0]   snap_sat_m, snap_sat_s;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          seq;
    int          cyc;
    logic [63:0] ev0, ev1, by0, by1;
    logic [1:0]  sat;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];
  exp_t em, es;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

  net_perf_monitor #(.NUM_CH(2)) u_dut (
    .aclk(aclk), .areset(areset), .arm(arm), .mode(mode),
    .window_cycles(window_cycles), .trig_sel(trig_sel),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ok(ev_ok), .ev_len(ev_len),
    .running(running_m), .snap_valid(snap_valid_m), .snap_seq(snap_seq_m),
    .snap_events(snap_events_m), .snap_bytes(snap_bytes_m), .snap_sat(snap_sat_m)
  );

  net_perf_monitor #(.NUM_CH(2), .EVT_W(4)) u_sat (
    .aclk(aclk), .areset(areset), .arm(arm_s), .mode(mode),
    .window_cycles(window_cycles), .trig_sel(trig_sel),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ok(ev_ok), .ev_len(ev_len),
    .running(running_s), .snap_valid(snap_valid_s), .snap_seq(snap_seq_s),
    .snap_events(snap_events_s), .snap_bytes(snap_bytes_s), .snap_sat(snap_sat_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ch(input int ch, input bit v, input bit ok, input int len);
    ev_valid[ch] = v;
    ev_ok[ch]    = ok;
    ev_len[ch*16 +: 16] = 16'(len);
  endtask

  // Scoreboard monitors: compare every snapshot pulse against the queue head.
  always @(negedge aclk) begin
    if (snap_valid_m) begin
      if (q_main.size() == 0) begin
        checks++; errors++;
        $display("FAIL main_unexpected_snap: got snap_valid=1 at cycle %0d expected 0", cyc_cnt);
      end else begin
        em = q_main.pop_front();
        $display("main snap seq=%0d cycle=%0d ev0=%0d ev1=%0d", snap_seq_m, cyc_cnt,
                 snap_events_m[31:0], snap_events_m[63:32]);
        check("main_cycle", 64'(cyc_cnt), 64'(em.cyc));
        check("main_seq",   64'(snap_seq_m), 64'(em.seq));
        check("main_ev0",   64'(snap_events_m[31:0]), em.ev0);
        check("main_ev1",   64'(snap_events_m[63:32]), em.ev1);
        check("main_by0",   snap_bytes_m[63:0], em.by0);
        check("main_by1",   snap_bytes_m[127:64], em.by1);
        check("main_sat",   64'(snap_sat_m), 64'(em.sat));
      end
    end
    if (snap_valid_s) begin
      if (q_sat.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_unexpected_snap: got snap_valid=1 at cycle %0d expected 0", cyc_cnt);
      end else begin
        es = q_sat.pop_front();
        $display("sat snap seq=%0d cycle=%0d ev0=%0d sat=%0d", snap_seq_s, cyc_cnt,
                 snap_events_s[3:0], snap_sat_s);
        check("sat_cycle", 64'(cyc_cnt), 64'(es.cyc));
        check("sat_seq",   64'(snap_seq_s), 64'(es.seq));
        check("sat_ev0",   64'(snap_events_s[3:0]), es.ev0);
        check("sat_ev1",   64'(snap_events_s[7:4]), es.ev1);
        check("sat_by0",   snap_bytes_s[63:0], es.by0);
        check("sat_flag",  64'(snap_sat_s), 64'(es.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    areset = 1'b1; arm = 1'b0; arm_s = 1'b0; mode = 1'b0; trig_sel = 1'b0;
    window_cycles = 32'd10; ev_valid = '0; ev_ready = 2'b11; ev_ok = '0; ev_len = '0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    check("rst_running", 64'(running_m), 64'd0);
    check("rst_snap_valid", 64'(snap_valid_m), 64'd0);
    check("rst_seq", 64'(snap_seq_m), 64'd0);
    check("rst_events", snap_events_m, 64'd0);
    check("rst_bytes", snap_bytes_m[63:0] | snap_bytes_m[127:64], 64'd0);
    check("rst_sat", 64'(snap_sat_m), 64'd0);

    // One-shot, 10-cycle window triggered by channel 0.
    arm = 1'b1; mode = 1'b0; window_cycles = 32'd10; trig_sel = 1'b0;
    step();
    set_ch(0, 1, 1, 5); set_ch(1, 1, 1, 64);
    t = cyc_cnt;
    q_main.push_back('{1, t + 10, 64'd1, 64'd10, 64'(5 * BEN), 64'(640 * BEN), 2'b00});
    step();
    set_ch(0, 0, 0, 0);
    check("oneshot_running_up", 64'(running_m), 64'd1);
    for (int i = 2; i <= 10; i++) begin
      step();
      if (i == 10) check("oneshot_running_down", 64'(running_m), 64'd0);
    end
    step();
    set_ch(1, 0, 0, 0);

    // Continuous: three 5-cycle windows, channel 0 firing every cycle.
    mode = 1'b1; window_cycles = 32'd5;
    set_ch(0, 1, 1, 10);
    t = cyc_cnt;
    for (int k = 1; k <= 3; k++)
      q_main.push_back('{1 + k, t + 5 * k, 64'd5, 64'd0, 64'(50 * BEN), 64'd0, 2'b00});
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 10) check("cont_running", 64'(running_m), 64'd1);
      if (i == 14) mode = 1'b0;
      if (i == 15) begin
        set_ch(0, 0, 0, 0);
        check("cont_running_down", 64'(running_m), 64'd0);
      end
    end

    // 100-cycle window on channel 1 with ev_ok on alternate fires.
    trig_sel = 1'b1; window_cycles = 32'd100; mode = 1'b0;
    step();
    set_ch(1, 1, 1, 7);
    t = cyc_cnt;
    q_main.push_back('{5, t + 100, 64'd0, 64'd50, 64'd0, 64'(350 * BEN), 2'b00});
    for (int i = 1; i <= 99; i++) begin
      step();
      ev_ok[1] = (i % 2 == 0);
    end
    step();
    set_ch(1, 0, 0, 0);

    // Abort at window cycle 7 of 10, then abort on the final cycle.
    trig_sel = 1'b0; window_cycles = 32'd10;
    step();
    set_ch(0, 1, 1, 3);
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 7) arm = 1'b0;
    end
    step();
    check("abort_running", 64'(running_m), 64'd0);
    check("abort_seq", 64'(snap_seq_m), 64'd5);
    check("abort_ev1_kept", 64'(snap_events_m[63:32]), 64'd50);
    arm = 1'b1;
    step();
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 9) arm = 1'b0;
    end
    step();
    check("abort_last_running", 64'(running_m), 64'd0);
    check("abort_last_seq", 64'(snap_seq_m), 64'd5);
    set_ch(0, 0, 0, 0);

    // window_cycles = 0 behaves as a single-cycle window.
    arm = 1'b1; window_cycles = 32'd0;
    step();
    set_ch(0, 1, 1, 9);
    t = cyc_cnt;
    q_main.push_back('{6, t + 1, 64'd1, 64'd0, 64'(9 * BEN), 64'd0, 2'b00});
    step();
    set_ch(0, 0, 0, 0);
    check("w0_running", 64'(running_m), 64'd0);
    step();
    arm = 1'b0;
    step(); step();

    // Saturation on the 4-bit instance: 20 fires, then 3 fires.
    arm_s = 1'b1; mode = 1'b1; window_cycles = 32'd20;
    step();
    set_ch(0, 1, 1, 1);
    t = cyc_cnt;
    q_sat.push_back('{1, t + 20, 64'd15, 64'd0, 64'(20 * BEN), 64'd0, 2'b01});
    q_sat.push_back('{2, t + 40, 64'd3, 64'd0, 64'(3 * BEN), 64'd0, 2'b00});
    for (int i = 1; i <= 39; i++) begin
      step();
      if (i == 20) mode = 1'b0;
      if (i == 23) set_ch(0, 0, 0, 0);
    end
    step();
    arm_s = 1'b0;
    step();

    // Asynchronous reset in the middle of a window.
    arm = 1'b1; window_cycles = 32'd10;
    step();
    set_ch(0, 1, 1, 4);
    step(); step();
    check("pre_reset_running", 64'(running_m), 64'd1);
    #2 areset = 1'b1;
    #1;
    check("areset_running", 64'(running_m), 64'd0);
    check("areset_snap_valid", 64'(snap_valid_m), 64'd0);
    check("areset_seq", 64'(snap_seq_m), 64'd0);
    check("areset_events", snap_events_m, 64'd0);
    check("areset_bytes", snap_bytes_m[63:0] | snap_bytes_m[127:64], 64'd0);
    check("areset_sat", 64'(snap_sat_m), 64'd0);
    check("areset_sat_seq", 64'(snap_seq_s), 64'd0);
    check("areset_sat_events", 64'(snap_events_s), 64'd0);
    set_ch(0, 0, 0, 0); arm = 1'b0;
    @(posedge aclk);
    #1 areset = 1'b0;
    step(); step();

    check("main_queue_empty", 64'(q_main.size()), 64'd0);
    check("sat_queue_empty", 64'(q_sat.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
